// File: rtl/uart_pkg.sv
// Shared UART receive-path types: error flags, FIFO trigger encoding,
// receive-timeout states and the trigger-level helper.
package uart_pkg;

    // Field width of rx_err_s; matches the buffer's default ERR_W.
    localparam int RX_ERR_W = 3;

    typedef struct packed {
        logic brk;
        logic framing;
        logic parity;
    } rx_err_s;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_14 = 2'd3
    } fifo_trig_e;

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_COUNT,
        TO_TIMEOUT
    } rx_to_state_e;

    // Entry count at which the data-ready interrupt fires.
    function automatic int trig_level(fifo_trig_e trig, int depth);
        int lvl;
        lvl = 1;
        case (trig)
            TRIG_1:  lvl = 1;
            TRIG_4:  lvl = depth / 4;
            TRIG_8:  lvl = depth / 2;
            TRIG_14: lvl = depth - 2;
            default: lvl = 1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_mem.sv
// Receive FIFO storage: DEPTH x W register array, sync write, async read.
// Ports: clk, rst (clears array), we/waddr/wdata, raddr/rdata.
module uart_rx_buffer_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [W-1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [W-1:0]               rdata
);

    logic [W-1:0] mem [DEPTH];

    // Only rst clears the array; a flush just moves the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: FWFT FIFO with per-entry error side-band, error
// count, fill level, data-ready trigger and character-timeout interrupt.
// Ports: clk/rst; rx_valid/rx_data/rx_err in; rhr_valid/rhr_ready/
// rhr_data/rhr_err out; cfg_fifo_enable/cfg_rx_reset/cfg_fifo_trig;
// char_tick; level, rx_overrun, rx_fifo_err, int_rx_data_ready,
// int_rx_timeout.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 16,
    parameter int ERR_W         = 3,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic [ERR_W-1:0]         rx_err,
    output logic                     rhr_valid,
    input  logic                     rhr_ready,
    output logic [DATA_W-1:0]        rhr_data,
    output logic [ERR_W-1:0]         rhr_err,
    input  logic                     cfg_fifo_enable,
    input  logic                     cfg_rx_reset,
    input  logic [1:0]               cfg_fifo_trig,
    input  logic                     char_tick,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rx_overrun,
    output logic                     rx_fifo_err,
    output logic                     int_rx_data_ready,
    output logic                     int_rx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CHARS + 1);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   err_cnt;
    logic [AW:0]   cap;
    logic [AW:0]   trig;
    logic [AW:0]   level_nxt;
    logic          flush;
    logic          full;
    logic          push_ok;
    logic          pop;
    logic          push_err;
    logic          pop_err;
    logic [DATA_W+ERR_W-1:0] head;

    rx_to_state_e  to_state;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_next;

    assign flush = rst | cfg_rx_reset;
    assign level = wr_ptr - rd_ptr;
    assign cap   = cfg_fifo_enable ? LW'(DEPTH) : LW'(1);

    // Full comes from registered state, so a same-cycle pop
    // does not make room for the incoming character.
    assign full       = (level >= cap);
    assign push_ok    = rx_valid & ~full & ~flush;
    assign rx_overrun = rx_valid & full & ~flush;

    assign rhr_valid = (level != '0);
    assign pop       = rhr_valid & rhr_ready;

    // Empty reads as zero even if stale words remain after a flush.
    assign {rhr_data, rhr_err} = rhr_valid ? head : '0;

    assign push_err  = push_ok & (|rx_err);
    assign pop_err   = pop & (|rhr_err);
    assign level_nxt = level + LW'(push_ok) - LW'(pop);

    uart_rx_buffer_mem #(
        .DEPTH (DEPTH),
        .W     (DATA_W + ERR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({rx_data, rx_err}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_cnt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + LW'(push_ok);
            rd_ptr  <= rd_ptr + LW'(pop);
            err_cnt <= err_cnt + LW'(push_err) - LW'(pop_err);
        end
    end

    // Counting error entries avoids an OR across the whole array.
    assign rx_fifo_err = (err_cnt != '0);

    assign trig = cfg_fifo_enable
                ? LW'(trig_level(fifo_trig_e'(cfg_fifo_trig), DEPTH))
                : LW'(1);

    assign int_rx_data_ready = (level >= trig);

    // tick_cnt is held at 0 outside COUNT/TIMEOUT, so it can be
    // advanced directly; it saturates at TIMEOUT_CHARS.
    assign tick_next = (tick_cnt >= TW'(TIMEOUT_CHARS))
                     ? TW'(TIMEOUT_CHARS)
                     : tick_cnt + TW'(char_tick);

    always_ff @(posedge clk) begin
        if (flush || !cfg_fifo_enable || level_nxt == '0) begin
            to_state       <= TO_IDLE;
            tick_cnt       <= '0;
            int_rx_timeout <= 1'b0;
        end else if (push_ok || pop) begin
            to_state       <= TO_COUNT;
            tick_cnt       <= '0;
            int_rx_timeout <= 1'b0;
        end else begin
            tick_cnt <= tick_next;
            if (tick_next >= TW'(TIMEOUT_CHARS)) begin
                to_state       <= TO_TIMEOUT;
                int_rx_timeout <= 1'b1;
            end else begin
                to_state       <= TO_COUNT;
                int_rx_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int TOC   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rhr_valid;
    logic       rhr_ready;
    logic [7:0] rhr_data;
    logic [2:0] rhr_err;
    logic       cfg_fifo_enable;
    logic       cfg_rx_reset;
    logic [1:0] cfg_fifo_trig;
    logic       char_tick;
    logic [4:0] level;
    logic       rx_overrun;
    logic       rx_fifo_err;
    logic       int_rx_data_ready;
    logic       int_rx_timeout;

    uart_rx_buffer #(
        .DATA_W(8), .DEPTH(DEPTH), .ERR_W(3), .TIMEOUT_CHARS(TOC)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .rhr_valid(rhr_valid), .rhr_ready(rhr_ready),
        .rhr_data(rhr_data), .rhr_err(rhr_err),
        .cfg_fifo_enable(cfg_fifo_enable),
        .cfg_rx_reset(cfg_rx_reset),
        .cfg_fifo_trig(cfg_fifo_trig),
        .char_tick(char_tick), .level(level),
        .rx_overrun(rx_overrun), .rx_fifo_err(rx_fifo_err),
        .int_rx_data_ready(int_rx_data_ready),
        .int_rx_timeout(int_rx_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ovr_cnt = 0;
    bit mon_on = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h",
                      nm, $time, act, exp);
    endtask

    // Reference model: FIFO contents as a queue, timeout as a count of
    // idle character ticks since the last push/pop.
    typedef struct { logic [7:0] d; logic [2:0] e; } ent_t;
    ent_t mq[$];
    int   m_ticks = 0;
    bit   m_to = 0;

    always @(negedge clk) begin : model
        int  sz, cap, trg;
        bit  full, pushed, popped, anyerr;
        logic [7:0] ed;
        logic [2:0] ee;
        sz  = mq.size();
        cap = cfg_fifo_enable ? DEPTH : 1;
        full = (sz >= cap);
        case (cfg_fifo_trig)
            2'd0: trg = 1;
            2'd1: trg = DEPTH / 4;
            2'd2: trg = DEPTH / 2;
            default: trg = DEPTH - 2;
        endcase
        if (!cfg_fifo_enable) trg = 1;
        anyerr = 0;
        foreach (mq[i]) if (mq[i].e != 3'd0) anyerr = 1;
        ed = 8'd0;
        ee = 3'd0;
        if (sz != 0) begin
            ed = mq[0].d;
            ee = mq[0].e;
        end
        if (rx_overrun === 1'b1) ovr_cnt++;
        if (mon_on) begin
            check("level", level, sz);
            check("rhr_valid", rhr_valid, sz != 0);
            check("rhr_data", rhr_data, ed);
            check("rhr_err", rhr_err, ee);
            check("rx_overrun", rx_overrun,
                  rx_valid && full && !rst && !cfg_rx_reset);
            check("rx_fifo_err", rx_fifo_err, anyerr);
            check("int_data_ready", int_rx_data_ready, sz >= trg);
            check("int_timeout", int_rx_timeout, m_to);
        end
        if (rst || cfg_rx_reset) begin
            mq.delete();
            m_ticks = 0;
            m_to = 0;
        end else begin
            pushed = rx_valid && !full;
            popped = (sz != 0) && rhr_ready;
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back('{rx_data, rx_err});
            if (!cfg_fifo_enable || mq.size() == 0 || pushed || popped) begin
                m_ticks = 0;
                m_to = 0;
            end else if (char_tick) begin
                if (m_ticks < TOC) m_ticks++;
                m_to = (m_ticks >= TOC);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        rx_valid = 1'b1;
        rx_data = d;
        rx_err = e;
        cyc();
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic pop();
        rhr_ready = 1'b1;
        cyc();
        rhr_ready = 1'b0;
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            char_tick = 1'b1;
            cyc();
            char_tick = 1'b0;
        end
        #1;
    endtask

    task automatic flush();
        cfg_rx_reset = 1'b1;
        cyc();
        cfg_rx_reset = 1'b0;
        #1;
    endtask

    initial begin
        int ov0;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        rx_err = '0;
        rhr_ready = 1'b0;
        cfg_fifo_enable = 1'b1;
        cfg_rx_reset = 1'b0;
        cfg_fifo_trig = 2'd2;
        char_tick = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        mon_on = 1;

        check("rst_level", level, 0);
        check("rst_valid", rhr_valid, 0);
        check("rst_data", rhr_data, 0);
        check("rst_ferr", rx_fifo_err, 0);
        check("rst_to", int_rx_timeout, 0);

        ov0 = ovr_cnt;
        for (int i = 0; i < 16; i++) push(8'(i), 3'd0);
        push(8'h55, 3'd0);
        check("fill_level", level, 16);
        check("fill_model", mq.size(), 16);
        check("fill_ovr", ovr_cnt - ov0, 1);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", rhr_data, i);
            pop();
        end
        check("drain_level", level, 0);

        for (int i = 0; i < 7; i++) push(8'h30 + 8'(i), 3'd0);
        check("trig8_7", int_rx_data_ready, 0);
        push(8'h37, 3'd0);
        check("trig8_8", int_rx_data_ready, 1);
        pop();
        check("trig8_pop", int_rx_data_ready, 0);
        flush();

        push(8'h01, 3'd0);
        push(8'h02, 3'b010);
        push(8'h03, 3'd0);
        check("err_set", rx_fifo_err, 1);
        pop();
        check("err_keep", rx_fifo_err, 1);
        check("err_head", rhr_err, 3'b010);
        pop();
        check("err_clr", rx_fifo_err, 0);
        flush();

        push(8'h44, 3'd0);
        ticks(3);
        check("to_3", int_rx_timeout, 0);
        ticks(1);
        check("to_4", int_rx_timeout, 1);
        check("to_model", m_to, 1);
        pop();
        check("to_pop", int_rx_timeout, 0);
        push(8'h45, 3'd0);
        ticks(3);
        push(8'h46, 3'd0);
        ticks(3);
        check("to_rst3", int_rx_timeout, 0);
        ticks(1);
        check("to_rst4", int_rx_timeout, 1);
        flush();

        cfg_fifo_enable = 1'b0;
        ov0 = ovr_cnt;
        push(8'hA1, 3'd0);
        push(8'hB2, 3'd0);
        check("off_ovr", ovr_cnt - ov0, 1);
        check("off_data", rhr_data, 8'hA1);
        check("off_level", level, 1);
        check("off_dr", int_rx_data_ready, 1);
        ticks(10);
        check("off_to", int_rx_timeout, 0);
        flush();
        cfg_fifo_enable = 1'b1;

        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), (i == 2) ? 3'b100 : 3'd0);
        ov0 = ovr_cnt;
        rx_valid = 1'b1;
        rx_data = 8'h77;
        cfg_rx_reset = 1'b1;
        cyc();
        rx_valid = 1'b0;
        cfg_rx_reset = 1'b0;
        #1;
        check("fl_level", level, 0);
        check("fl_ferr", rx_fifo_err, 0);
        check("fl_ovr", ovr_cnt - ov0, 0);
        check("fl_data", rhr_data, 0);
        push(8'h88, 3'd1);
        ticks(4);
        check("rst_to_pre", int_rx_timeout, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("rst_to_post", int_rx_timeout, 0);
        check("rst_to_lvl", level, 0);

        for (int blk = 0; blk < 8; blk++) begin
            int pv, pr;
            pv = (blk % 3 == 0) ? 50 : ((blk % 3 == 1) ? 15 : 3);
            pr = (blk % 2 == 1) ? 40 : 10;
            repeat (500) begin
                rx_valid = ($urandom_range(0, 99) < pv);
                rx_data = 8'($urandom);
                rx_err = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
                rhr_ready = ($urandom_range(0, 99) < pr);
                char_tick = ($urandom_range(0, 2) == 0);
                cfg_rx_reset = ($urandom_range(0, 299) == 0);
                rst = ($urandom_range(0, 799) == 0);
                if ($urandom_range(0, 199) == 0)
                    cfg_fifo_enable = ~cfg_fifo_enable;
                if ($urandom_range(0, 99) == 0)
                    cfg_fifo_trig = 2'($urandom);
                cyc();
            end
        end
        rx_valid = 1'b0;
        rhr_ready = 1'b0;
        char_tick = 1'b0;
        cfg_rx_reset = 1'b0;
        rst = 1'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Parametrised receive buffer between the UART RX deserialiser and the RHR register read path. It generalises data width, depth and error-flag width. It keeps a per-entry error side-band and a running count of erroneous entries, reports its fill level, and adds the 16550 character-timeout interrupt. It instantiates one storage sub-module and owns all pointer, counter and interrupt logic.

Parameters:
DATA_W, 8, character width in bits (5..9)
DEPTH, 16, FIFO entries; power of two, >= 4
ERR_W, 3, per-character error flags (uart_pkg::rx_err_s width: parity, framing, break)
TIMEOUT_CHARS, 4, character times of inactivity before int_rx_timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle pulse, character received
rx_data  in  DATA_W  received character
rx_err  in  ERR_W  error flags of received character
rhr_valid  out  1  head entry available
rhr_ready  in  1  consumer pops head when rhr_valid & rhr_ready
rhr_data  out  DATA_W  head character
rhr_err  out  ERR_W  head error flags
cfg_fifo_enable  in  1  1: capacity DEPTH; 0: capacity 1 (16450 mode)
cfg_rx_reset  in  1  synchronous flush
cfg_fifo_trig  in  2  uart_pkg::fifo_trig_e
char_tick  in  1  one-cycle pulse per character time (from baud generator)
level  out  $clog2(DEPTH)+1  current entry count
rx_overrun  out  1  one-cycle pulse, character dropped
rx_fifo_err  out  1  any stored entry has nonzero error flags
int_rx_data_ready  out  1  level >= trigger level
int_rx_timeout  out  1  character-timeout interrupt

Behaviour:
- Reset priority: rst > cfg_rx_reset > push/pop. Both clear pointers, level, error count and timeout state. All outputs are 0 the cycle after; rhr_data/rhr_err then read 0. A push in the reset cycle is dropped without setting rx_overrun.
- Pointers are AW+1 bits, where AW = $clog2(DEPTH); wrap-around is natural modulo 2*DEPTH. level = wr_ptr - rd_ptr.
- Capacity CAP = cfg_fifo_enable ? DEPTH : 1. full = (level >= CAP).
- Push: rx_valid & ~full writes data and flags at wr_ptr[AW-1:0]. rx_valid & full drops the character and rx_overrun = 1 in the same cycle (combinational). Full with a simultaneous pop still overruns: the full decision uses registered state.
- Pop: rhr_valid = (level != 0). rhr_data/rhr_err show the head combinationally; zero-latency first-word fall-through, so a push is visible on the next cycle.
- Simultaneous push and pop with 0 < level < CAP: level is unchanged.
- Toggling cfg_fifo_enable does not flush. If level > CAP after the change, entries drain normally and no push is accepted until level < CAP.
- Error count err_cnt (AW+1 bits): +1 on an accepted push with |rx_err, -1 on a pop whose head has |rhr_err. A simultaneous +1/-1 nets to 0. rx_fifo_err = (err_cnt != 0).
- Trigger level: TRIG_1 -> 1, TRIG_4 -> DEPTH/4, TRIG_8 -> DEPTH/2, TRIG_14 -> DEPTH-2. When cfg_fifo_enable = 0 the trigger is forced to 1. int_rx_data_ready = level >= trigger (combinational from registered level).
- Timeout FSM (active only when cfg_fifo_enable = 1):
  - IDLE: level == 0. Go to COUNT when level != 0.
  - COUNT: tick_cnt increments on char_tick. tick_cnt clears on an accepted push or a pop. When tick_cnt reaches TIMEOUT_CHARS, go to TIMEOUT.
  - TIMEOUT: int_rx_timeout = 1. An accepted push or a pop goes back to COUNT with tick_cnt = 0, or to IDLE if level becomes 0.
  - level == 0 forces IDLE from any state.
  - cfg_fifo_enable = 0 forces IDLE with int_rx_timeout = 0.
- int_rx_timeout is registered (asserts the cycle after the TIMEOUT_CHARS-th tick). tick_cnt saturates.

Decomposition:
- uart_pkg: rx_err_s (resized to ERR_W), fifo_trig_e, a trig_level function of (trig, DEPTH), and a timeout state enum rx_to_state_e.
- Sub-module uart_rx_buffer_mem: DEPTH x (DATA_W+ERR_W) register array with sync write and async read. It is cleared on rst only; flags are not cleared on pop, because err_cnt replaces the OR-over-array.

Test Plan:
- DEPTH=16, FIFO on: push 16 chars 0x00..0x0F, then push 0x55 -> level=16, rx_overrun pulses once, 0x55 absent; 16 pops return 0x00..0x0F in order, level returns to 0.
- TRIG_8: push 7 -> int_rx_data_ready=0; 8th push -> 1 next cycle; pop one -> 0.
- Push 3 chars with rx_err=3'b010 on the 2nd -> rx_fifo_err=1; pop 1st: still 1, rhr_err=3'b010; pop 2nd -> rx_fifo_err=0.
- Push 1 char, issue 4 char_ticks -> int_rx_timeout=1 one cycle after the 4th tick; a pop clears it. Repeat with a push after the 3rd tick -> no timeout until 4 further ticks.
- FIFO off: push 0xA1, then push 0xB2 -> overrun pulse, rhr_data=0xA1, level=1, int_rx_data_ready=1, no timeout after 10 ticks.
- Push 5 chars (one with error), assert cfg_rx_reset concurrently with a push -> next cycle level=0, rx_fifo_err=0, no overrun pulse. Repeat with rst mid-TIMEOUT -> int_rx_timeout=0.
